// File: rtl/sprite_motion_sequencer.sv
// Shared add/compare motion sweep for the bouncing-square display.
// One object per LOAD/CALC/WRITE triple, triggered once per vblank.
module sprite_motion_sequencer #(
  parameter int NUM_OBJ  = 5,
  parameter int H_LIMIT  = 640,
  parameter int V_LIMIT  = 480,
  parameter int OBJ_SIZE = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               freeze,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_idx,
  input  logic [9:0]         cfg_x,
  input  logic [9:0]         cfg_y,
  input  logic [3:0]         cfg_dx,
  input  logic [3:0]         cfg_dy,
  input  logic [1:0]         cfg_dir,
  output logic               cfg_ack,
  input  logic [2:0]         rd_idx,
  output logic [9:0]         rd_x,
  output logic [9:0]         rd_y,
  output logic               busy,
  output logic               update_done,
  output logic [NUM_OBJ-1:0] bounce_evt,
  output logic               overrun
);

  localparam logic [9:0] X_MAX =
    10'(H_LIMIT - OBJ_SIZE);
  localparam logic [9:0] Y_MAX =
    10'(V_LIMIT - OBJ_SIZE);
  localparam logic [3:0] N_OBJ =
    4'(NUM_OBJ);
  localparam logic [2:0] LAST =
    3'(NUM_OBJ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [7:0][9:0] pos_x;
  logic [7:0][9:0] pos_y;
  logic [7:0][3:0] spd_x;
  logic [7:0][3:0] spd_y;
  logic [7:0]      dir_x;
  logic [7:0]      dir_y;

  logic [2:0]  idx;

  logic [9:0]  w_x;
  logic [9:0]  w_y;
  logic [3:0]  w_dx;
  logic [3:0]  w_dy;
  logic        w_dir_x;
  logic        w_dir_y;

  logic [9:0]  c_x;
  logic [9:0]  c_y;
  logic        hit_x;
  logic        hit_y;

  logic [10:0] sum_x;
  logic [10:0] sum_y;
  logic [9:0]  dif_x;
  logic [9:0]  dif_y;

  logic [NUM_OBJ-1:0] bev;

  logic go;
  logic cfg_ok;

  assign go = (state == S_IDLE)
            & frame_tick
            & ~freeze;

  assign cfg_ok = (state == S_IDLE)
                & cfg_we
                & ({1'b0, cfg_idx} < N_OBJ);

  assign sum_x = {1'b0, w_x}
               + {7'b0, w_dx};
  assign sum_y = {1'b0, w_y}
               + {7'b0, w_dy};
  assign dif_x = w_x - {6'b0, w_dx};
  assign dif_y = w_y - {6'b0, w_dy};

  assign rd_x = ({1'b0, rd_idx} < N_OBJ)
              ? pos_x[rd_idx] : '0;
  assign rd_y = ({1'b0, rd_idx} < N_OBJ)
              ? pos_y[rd_idx] : '0;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state: one LOAD/CALC/WRITE triple per object
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (go) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_CALC;
      S_CALC:  state_nx = S_WRITE;
      S_WRITE: state_nx = (idx == LAST)
                        ? S_DONE : S_LOAD;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore outputs; bounce flags exposed only in DONE
  always_comb begin
    busy        = 1'b0;
    update_done = 1'b0;
    bounce_evt  = '0;
    unique case (state)
      S_LOAD,
      S_CALC,
      S_WRITE: busy = 1'b1;
      S_DONE: begin
        update_done = 1'b1;
        bounce_evt  = bev;
      end
      default: ;
    endcase
  end

  // object index walks 0..NUM_OBJ-1 within a sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idx <= '0;
    else if (go)
      idx <= '0;
    else if (state == S_WRITE && idx != LAST)
      idx <= idx + 3'd1;
  end

  // object table: config writes in IDLE, bounced write-back in WRITE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        if (k < NUM_OBJ) begin
          pos_x[k] <= 10'(k * OBJ_SIZE);
          pos_y[k] <= 10'((k * (OBJ_SIZE / 2))
                      % (V_LIMIT - OBJ_SIZE));
          spd_x[k] <= 4'((k + 1 > 15) ? 15 : k + 1);
          spd_y[k] <= 4'((k + 2 > 15) ? 15 : k + 2);
          dir_x[k] <= 1'b1;
          dir_y[k] <= 1'b1;
        end else begin
          pos_x[k] <= '0;
          pos_y[k] <= '0;
          spd_x[k] <= '0;
          spd_y[k] <= '0;
          dir_x[k] <= 1'b0;
          dir_y[k] <= 1'b0;
        end
      end
    end else if (cfg_ok) begin
      pos_x[cfg_idx] <= (cfg_x > X_MAX)
                      ? X_MAX : cfg_x;
      pos_y[cfg_idx] <= (cfg_y > Y_MAX)
                      ? Y_MAX : cfg_y;
      spd_x[cfg_idx] <= cfg_dx;
      spd_y[cfg_idx] <= cfg_dy;
      dir_x[cfg_idx] <= cfg_dir[1];
      dir_y[cfg_idx] <= cfg_dir[0];
    end else if (state == S_WRITE) begin
      if (hit_x) begin
        pos_x[idx] <= w_dir_x ? X_MAX : '0;
        dir_x[idx] <= ~w_dir_x;
      end else begin
        pos_x[idx] <= c_x;
      end
      if (hit_y) begin
        pos_y[idx] <= w_dir_y ? Y_MAX : '0;
        dir_y[idx] <= ~w_dir_y;
      end else begin
        pos_y[idx] <= c_y;
      end
    end
  end

  // shared datapath: latch in LOAD, add/compare in CALC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_x     <= '0;
      w_y     <= '0;
      w_dx    <= '0;
      w_dy    <= '0;
      w_dir_x <= 1'b0;
      w_dir_y <= 1'b0;
      c_x     <= '0;
      c_y     <= '0;
      hit_x   <= 1'b0;
      hit_y   <= 1'b0;
    end else if (state == S_LOAD) begin
      w_x     <= pos_x[idx];
      w_y     <= pos_y[idx];
      w_dx    <= spd_x[idx];
      w_dy    <= spd_y[idx];
      w_dir_x <= dir_x[idx];
      w_dir_y <= dir_y[idx];
    end else if (state == S_CALC) begin
      c_x <= w_dir_x ? sum_x[9:0] : dif_x;
      c_y <= w_dir_y ? sum_y[9:0] : dif_y;
      // landing exactly on a limit is a bounce
      hit_x <= w_dir_x
             ? (sum_x >= {1'b0, X_MAX})
             : (w_x <= {6'b0, w_dx});
      hit_y <= w_dir_y
             ? (sum_y >= {1'b0, Y_MAX})
             : (w_y <= {6'b0, w_dy});
    end
  end

  // per-object bounce flags, cleared at sweep start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bev <= '0;
    end else if (go) begin
      bev <= '0;
    end else if (state == S_WRITE
                 && (hit_x || hit_y)) begin
      for (int k = 0; k < NUM_OBJ; k++)
        if (idx == 3'(k)) bev[k] <= 1'b1;
    end
  end

  // registered handshake and overrun pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ack <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cfg_ack <= cfg_ok;
      overrun <= frame_tick & ~freeze & busy;
    end
  end

endmodule

// File: tb/tb_sprite_motion_sequencer.sv
// Bench for sprite_motion_sequencer: directed cases plus random
// traffic against a frame-level motion model.
module tb_sprite_motion_sequencer;

  localparam int N   = 5;
  localparam int XM  = 576;
  localparam int YM  = 416;
  localparam int LAT = 3 * N + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         frame_tick = 1'b0;
  logic         freeze = 1'b0;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_idx = '0;
  logic [9:0]   cfg_x = '0;
  logic [9:0]   cfg_y = '0;
  logic [3:0]   cfg_dx = '0;
  logic [3:0]   cfg_dy = '0;
  logic [1:0]   cfg_dir = '0;
  logic         cfg_ack;
  logic [2:0]   rd_idx = '0;
  logic [9:0]   rd_x;
  logic [9:0]   rd_y;
  logic         busy;
  logic         update_done;
  logic [N-1:0] bounce_evt;
  logic         overrun;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  sprite_motion_sequencer #(
    .NUM_OBJ(N),
    .H_LIMIT(640),
    .V_LIMIT(480),
    .OBJ_SIZE(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_tick(frame_tick),
    .freeze(freeze),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_x(cfg_x),
    .cfg_y(cfg_y),
    .cfg_dx(cfg_dx),
    .cfg_dy(cfg_dy),
    .cfg_dir(cfg_dir),
    .cfg_ack(cfg_ack),
    .rd_idx(rd_idx),
    .rd_x(rd_x),
    .rd_y(rd_y),
    .busy(busy),
    .update_done(update_done),
    .bounce_evt(bounce_evt),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endfunction

  // frame-level model: whole sweep computed at once
  int       mx[N];
  int       my[N];
  int       mdx[N];
  int       mdy[N];
  bit       mdirx[N];
  bit       mdiry[N];
  int       p;
  bit [N-1:0] mbev;
  bit       e_ack;
  bit       e_ov;

  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      mx[k] = k * 64;
      my[k] = (k * 32) % YM;
      mdx[k] = (k + 1 > 15) ? 15 : k + 1;
      mdy[k] = (k + 2 > 15) ? 15 : k + 2;
      mdirx[k] = 1'b1;
      mdiry[k] = 1'b1;
    end
    p = 0;
    mbev = '0;
    e_ack = 1'b0;
    e_ov = 1'b0;
  endtask

  function automatic void m_axis(inout int pos, input int spd,
                                 inout bit dir, input int lim,
                                 output bit b);
    b = 1'b0;
    if (dir) begin
      if (pos + spd >= lim) begin
        pos = lim; dir = 1'b0; b = 1'b1;
      end else pos = pos + spd;
    end else begin
      if (pos <= spd) begin
        pos = 0; dir = 1'b1; b = 1'b1;
      end else pos = pos - spd;
    end
  endfunction

  task automatic m_sweep();
    for (int k = 0; k < N; k++) begin
      int px, py;
      bit ddx, ddy, bx, by;
      px = mx[k]; py = my[k];
      ddx = mdirx[k]; ddy = mdiry[k];
      m_axis(px, mdx[k], ddx, XM, bx);
      m_axis(py, mdy[k], ddy, YM, by);
      mx[k] = px; my[k] = py;
      mdirx[k] = ddx; mdiry[k] = ddy;
      mbev[k] = bx | by;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : mdl
    bit a, o;
    int ci;
    if (!rst_n) begin
      m_reset();
    end else begin
      ci = int'(cfg_idx);
      a = (p == 0) && cfg_we && (ci < N);
      o = (p >= 1) && (p <= LAT - 1)
          && frame_tick && !freeze;
      if (a) begin
        mx[ci] = (int'(cfg_x) > XM) ? XM : int'(cfg_x);
        my[ci] = (int'(cfg_y) > YM) ? YM : int'(cfg_y);
        mdx[ci] = int'(cfg_dx);
        mdy[ci] = int'(cfg_dy);
        mdirx[ci] = cfg_dir[1];
        mdiry[ci] = cfg_dir[0];
      end
      if (p == 0) begin
        if (frame_tick && !freeze) begin
          m_sweep();
          p = 1;
        end
      end else if (p < LAT) p++;
      else p = 0;
      e_ack = a;
      e_ov = o;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    int ri, ex, ey;
    #2;
    if (chk_en) begin
      chk("busy", busy, (p >= 1 && p <= LAT - 1) ? 1 : 0);
      chk("update_done", update_done, (p == LAT) ? 1 : 0);
      chk("bounce_evt", int'(bounce_evt),
          (p == LAT) ? int'(mbev) : 0);
      chk("cfg_ack", cfg_ack, e_ack ? 1 : 0);
      chk("overrun", overrun, e_ov ? 1 : 0);
      if (p == 0 || p == LAT) begin
        ri = int'(rd_idx);
        ex = (ri < N) ? mx[ri] : 0;
        ey = (ri < N) ? my[ri] : 0;
        chk("rd_x", rd_x, ex);
        chk("rd_y", rd_y, ey);
      end
    end
  end

  task automatic pulse_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc,
                           output logic [N-1:0] bv);
    lat = 1; bc = 0;
    while (!update_done && lat < 40) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    bv = bounce_evt;
    if (!update_done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no update_done in %0d cycles",
               lat);
    end
  endtask

  task automatic tick_wait(output int lat, output int bc,
                           output logic [N-1:0] bv);
    pulse_tick();
    wait_done(lat, bc, bv);
  endtask

  task automatic cfg_try(input int i, input int x, input int y,
                         input int dx, input int dy, input int d,
                         output bit ack);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'(i);
    cfg_x = 10'(x); cfg_y = 10'(y);
    cfg_dx = 4'(dx); cfg_dy = 4'(dy);
    cfg_dir = 2'(d);
    @(negedge clk);
    cfg_we = 1'b0;
    ack = cfg_ack;
  endtask

  task automatic cfg_write(input int i, input int x, input int y,
                           input int dx, input int dy, input int d,
                           output bit ack);
    ack = 1'b0;
    for (int t = 0; t < 4 && !ack; t++)
      cfg_try(i, x, y, dx, dy, d, ack);
  endtask

  task automatic rd_at(input int i, output int x, output int y);
    @(negedge clk);
    rd_idx = 3'(i);
    #1;
    x = int'(rd_x);
    y = int'(rd_y);
  endtask

  initial begin : stim
    int lat, bc, x, y, ov, dn;
    logic [N-1:0] bv;
    bit ack;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rd_at(1, x, y);
    chk("rst_x1", x, 64); chk("rst_y1", y, 32);
    rd_at(4, x, y);
    chk("rst_x4", x, 256); chk("rst_y4", y, 128);
    rd_at(7, x, y);
    chk("rst_x7", x, 0);
    @(negedge clk); rst_n = 1'b1;

    tick_wait(lat, bc, bv);
    chk("latency", lat, 16);
    chk("busy_len", bc, 15);
    chk("bev_first", int'(bv), 0);
    rd_at(0, x, y);
    chk("s1_x0", x, 1); chk("s1_y0", y, 2);
    rd_at(1, x, y);
    chk("s1_x1", x, 66); chk("s1_y1", y, 35);

    cfg_write(2, 570, 96, 8, 4, 3, ack);
    chk("ack_r", ack, 1);
    tick_wait(lat, bc, bv);
    chk("bev_r", int'(bv[2]), 1);
    rd_at(2, x, y);
    chk("right_x", x, 576);
    tick_wait(lat, bc, bv);
    chk("bev_r2", int'(bv[2]), 0);
    rd_at(2, x, y);
    chk("right_x2", x, 568);

    cfg_write(3, 3, 0, 5, 4, 0, ack);
    tick_wait(lat, bc, bv);
    chk("bev_l", int'(bv[3]), 1);
    rd_at(3, x, y);
    chk("left_x", x, 0); chk("top_y", y, 0);
    tick_wait(lat, bc, bv);
    rd_at(3, x, y);
    chk("left_x2", x, 5); chk("top_y2", y, 4);

    cfg_write(3, 7, 200, 7, 3, 1, ack);
    cfg_write(4, 571, 0, 5, 0, 2, ack);
    tick_wait(lat, bc, bv);
    chk("bev_exact3", int'(bv[3]), 1);
    chk("bev_exact4", int'(bv[4]), 1);
    rd_at(3, x, y);
    chk("exact_lo_x", x, 0);
    rd_at(4, x, y);
    chk("exact_hi_x", x, 576); chk("static_y", y, 0);
    tick_wait(lat, bc, bv);
    chk("bev_after4", int'(bv[4]), 0);
    rd_at(4, x, y);
    chk("exact_hi_x2", x, 571); chk("static_y2", y, 0);

    pulse_tick();
    cfg_try(0, 300, 300, 1, 1, 3, ack);
    chk("ack_busy", ack, 0);
    wait_done(lat, bc, bv);
    rd_at(0, x, y);
    chk("busy_cfg_x", x, 8); chk("busy_cfg_y", y, 16);

    cfg_try(6, 10, 10, 1, 1, 3, ack);
    chk("ack_idx6", ack, 0);
    cfg_write(1, 700, 10, 1, 1, 3, ack);
    chk("ack_clamp", ack, 1);
    rd_at(1, x, y);
    chk("clamp_x", x, 576);

    ov = 0; dn = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      frame_tick = (c == 0 || c == 5);
      if (overrun) ov++;
      if (update_done) dn++;
    end
    frame_tick = 1'b0;
    chk("ovr_pulses", ov, 1);
    chk("ovr_dones", dn, 1);
    rd_at(0, x, y);
    chk("ovr_x0", x, 9); chk("ovr_y0", y, 18);

    freeze = 1'b1; dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      frame_tick = (c % 8 == 0);
      if (update_done || overrun) dn++;
    end
    frame_tick = 1'b0; freeze = 1'b0;
    chk("freeze_done", dn, 0);

    pulse_tick();
    repeat (6) @(negedge clk);
    @(negedge clk);
    rd_idx = 3'd1;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", update_done, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_x1", rd_x, 64);
    chk("arst_y1", rd_y, 32);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (update_done) dn++;
    end
    chk("arst_nodone", dn, 0);
    tick_wait(lat, bc, bv);
    chk("arst_latency", lat, 16);
    rd_at(0, x, y);
    chk("arst_x0", x, 1); chk("arst_y0", y, 2);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 14) == 0);
      freeze = ($urandom_range(0, 9) == 0);
      cfg_we = ($urandom_range(0, 5) == 0);
      cfg_idx = 3'($urandom_range(0, 7));
      cfg_x = 10'($urandom_range(0, 1023));
      cfg_y = 10'($urandom_range(0, 1023));
      cfg_dx = 4'($urandom_range(0, 15));
      cfg_dy = 4'($urandom_range(0, 15));
      cfg_dir = 2'($urandom_range(0, 3));
      rd_idx = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    frame_tick = 1'b0; freeze = 1'b0; cfg_we = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
